// File: rtl/vdma_triple_buf_ctrl.sv
// Triple-buffer frame-slot scheduler: rotates three DDR frame slots between the
// VDMA write and read ports so the reader always gets the newest completed frame.
module vdma_triple_buf_ctrl #(
    parameter int          ASIZE      = 29,
    parameter int unsigned BASE_ADDR  = 32'd0,
    parameter int unsigned FRAME_STEP = 32'd2211840,
    parameter int          CNT_W      = 16
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             enable,
    input  logic             wr_frame_done,
    input  logic             rd_frame_start,
    output logic [ASIZE-1:0] wr_baseaddr,
    output logic [ASIZE-1:0] rd_baseaddr,
    output logic [1:0]       wr_idx,
    output logic [1:0]       rd_idx,
    output logic             frame_avail,
    output logic             rd_new_pulse,
    output logic             rd_repeat_pulse,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] repeat_cnt
);

    localparam logic [ASIZE-1:0] BASE_A = ASIZE'(BASE_ADDR);
    localparam logic [ASIZE-1:0] STEP_A = ASIZE'(FRAME_STEP);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Slot base address, wrapping modulo 2^ASIZE.
    function automatic logic [ASIZE-1:0] slot_addr(input logic [1:0] idx);
        slot_addr = BASE_A + STEP_A * {{(ASIZE-2){1'b0}}, idx};
    endfunction

    logic [1:0]       w_r, r_r;
    logic             v_r;
    logic             new_r, rep_r;
    logic [CNT_W-1:0] drop_r, repc_r;

    logic [1:0]       l_s, w_n_s, r_n_s;
    logic             v_n_s, new_n_s, rep_n_s;
    logic             drop_inc_s, rep_inc_s;
    logic [CNT_W-1:0] drop_n_s, repc_n_s;

    // W, R and L are distinct members of {0,1,2}, so the third slot is 3-W-R.
    assign l_s = 2'd3 - w_r - r_r;

    // Next-state decode for the slot rotation, flag and event pulses.
    always_comb begin
        w_n_s      = w_r;
        r_n_s      = r_r;
        v_n_s      = v_r;
        new_n_s    = 1'b0;
        rep_n_s    = 1'b0;
        drop_inc_s = 1'b0;
        rep_inc_s  = 1'b0;
        if (enable) begin
            case ({wr_frame_done, rd_frame_start})
                2'b10: begin
                    w_n_s      = l_s;
                    v_n_s      = 1'b1;
                    drop_inc_s = v_r;
                end
                2'b01: begin
                    if (v_r) begin
                        r_n_s   = l_s;
                        v_n_s   = 1'b0;
                        new_n_s = 1'b1;
                    end else begin
                        rep_n_s   = 1'b1;
                        rep_inc_s = 1'b1;
                    end
                end
                // Write applied first, then the read takes the just-finished slot.
                2'b11: begin
                    r_n_s      = w_r;
                    w_n_s      = l_s;
                    v_n_s      = 1'b0;
                    new_n_s    = 1'b1;
                    drop_inc_s = v_r;
                end
                default: begin
                    w_n_s = w_r;
                    r_n_s = r_r;
                    v_n_s = v_r;
                end
            endcase
        end else begin
            w_n_s = w_r;
            r_n_s = r_r;
            v_n_s = v_r;
        end
    end

    // Saturating counter increments.
    always_comb begin
        drop_n_s = drop_r;
        repc_n_s = repc_r;
        if (drop_inc_s && (drop_r != CNT_MAX)) begin
            drop_n_s = drop_r + CNT_W'(1);
        end else begin
            drop_n_s = drop_r;
        end
        if (rep_inc_s && (repc_r != CNT_MAX)) begin
            repc_n_s = repc_r + CNT_W'(1);
        end else begin
            repc_n_s = repc_r;
        end
    end

    // Slot state, flag, pulses and counters.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            w_r    <= 2'd0;
            r_r    <= 2'd1;
            v_r    <= 1'b0;
            new_r  <= 1'b0;
            rep_r  <= 1'b0;
            drop_r <= {CNT_W{1'b0}};
            repc_r <= {CNT_W{1'b0}};
        end else begin
            w_r    <= w_n_s;
            r_r    <= r_n_s;
            v_r    <= v_n_s;
            new_r  <= new_n_s;
            rep_r  <= rep_n_s;
            drop_r <= drop_n_s;
            repc_r <= repc_n_s;
        end
    end

    // Base addresses trail the slot indices by one cycle through the multiply-add.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_baseaddr <= slot_addr(2'd0);
            rd_baseaddr <= slot_addr(2'd1);
        end else begin
            wr_baseaddr <= slot_addr(w_r);
            rd_baseaddr <= slot_addr(r_r);
        end
    end

    assign wr_idx          = w_r;
    assign rd_idx          = r_r;
    assign frame_avail     = v_r;
    assign rd_new_pulse    = new_r;
    assign rd_repeat_pulse = rep_r;
    assign drop_cnt        = drop_r;
    assign repeat_cnt      = repc_r;

endmodule
